// File: rtl/multifun_pipe.sv
// multifun_pipe: two-stage valid/ready pipeline applying one of four bitwise
// functions (AND, OR, XOR, NAND) to WIDTH-bit operands, with an optional
// accumulator mode, zero/parity flags and a completed-transaction counter.
`timescale 1ns/1ps

module multifun_pipe #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       sel,
  input  logic             acc_mode,
  input  logic             acc_clr,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] f,
  output logic             zero,
  output logic             parity,
  output logic [CNT_W-1:0] txn_cnt
);

  localparam logic [1:0] FN_AND  = 2'b00;
  localparam logic [1:0] FN_OR   = 2'b01;
  localparam logic [1:0] FN_XOR  = 2'b10;

  // Stage 1: captured operand beat
  logic             v1_reg;
  logic [WIDTH-1:0] a1_reg;
  logic [WIDTH-1:0] b1_reg;
  logic [1:0]       sel1_reg;
  logic             accm1_reg;
  logic             clr1_reg;

  // Stage 2: registered result and flags
  logic             v2_reg;
  logic [WIDTH-1:0] f_reg;
  logic             zero_reg;
  logic             parity_reg;

  logic [WIDTH-1:0] acc_reg;
  logic [CNT_W-1:0] cnt_reg;

  // Handshake and flow-control terms
  logic             accept;
  logic             advance2;
  logic             out_hs;

  // Operands and result feeding stage 2
  logic [WIDTH-1:0] lhs;
  logic [WIDTH-1:0] rhs;
  logic [WIDTH-1:0] res_next;

  // Flow control: ready depends only on pipeline state and out_ready, never on in_valid
  always_comb begin
    advance2 = v1_reg && (!v2_reg || out_ready);
    in_ready = !v1_reg || advance2;
    accept   = in_valid && in_ready;
    out_hs   = v2_reg && out_ready;
  end

  // Operand selection: acc beats use the accumulator (or zero when clearing) as left operand
  always_comb begin
    lhs = a1_reg;
    rhs = b1_reg;
    if (accm1_reg) begin
      lhs = clr1_reg ? '0 : acc_reg;
      rhs = a1_reg;
    end
  end

  // Per-bit function unit
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      always_comb begin
        case (sel1_reg)
          FN_AND:  res_next[gi] = lhs[gi] & rhs[gi];
          FN_OR:   res_next[gi] = lhs[gi] | rhs[gi];
          FN_XOR:  res_next[gi] = lhs[gi] ^ rhs[gi];
          default: res_next[gi] = ~(lhs[gi] & rhs[gi]);
        endcase
      end
    end
  endgenerate

  // Stage 1 valid: set on accept, cleared when its beat moves on with nothing replacing it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_reg <= 1'b0;
    end else if (accept) begin
      v1_reg <= 1'b1;
    end else if (advance2) begin
      v1_reg <= 1'b0;
    end
  end

  // Stage 1 data: loaded only on accept, otherwise held
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a1_reg    <= '0;
      b1_reg    <= '0;
      sel1_reg  <= 2'b00;
      accm1_reg <= 1'b0;
      clr1_reg  <= 1'b0;
    end else if (accept) begin
      a1_reg    <= a;
      b1_reg    <= b;
      sel1_reg  <= sel;
      accm1_reg <= acc_mode;
      clr1_reg  <= acc_clr;
    end
  end

  // Stage 2 valid: set on advance, cleared on output handshake without a refill
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2_reg <= 1'b0;
    end else if (advance2) begin
      v2_reg <= 1'b1;
    end else if (out_hs) begin
      v2_reg <= 1'b0;
    end
  end

  // Stage 2 result and flags: updated together so the flags always describe f
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_reg      <= '0;
      zero_reg   <= 1'b1;
      parity_reg <= 1'b0;
    end else if (advance2) begin
      f_reg      <= res_next;
      zero_reg   <= (res_next == '0);
      parity_reg <= ^res_next;
    end
  end

  // Accumulator: touched only at stage-2 advance so beats see it in arrival order
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_reg <= '0;
    end else if (advance2) begin
      if (accm1_reg) begin
        acc_reg <= res_next;
      end else if (clr1_reg) begin
        acc_reg <= '0;
      end
    end
  end

  // Completed-transaction counter, wraps naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (out_hs) begin
      cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

  assign out_valid = v2_reg;
  assign f         = f_reg;
  assign zero      = zero_reg;
  assign parity    = parity_reg;
  assign txn_cnt   = cnt_reg;

endmodule

// File: tb/tb_multifun_pipe.sv
// Testbench for multifun_pipe: directed scenarios plus randomized traffic,
// checked against a transaction-level reference model.
`timescale 1ns/1ps

module tb_multifun_pipe;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [1:0] sel = 2'b00;
  logic       acc_mode = 1'b0;
  logic       acc_clr = 1'b0;
  logic [7:0] a = 8'h00;
  logic [7:0] b = 8'h00;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] f;
  logic       zero;
  logic       parity;
  logic [7:0] txn_cnt;

  multifun_pipe #(.WIDTH(8), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .sel(sel), .acc_mode(acc_mode), .acc_clr(acc_clr),
    .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .f(f), .zero(zero), .parity(parity), .txn_cnt(txn_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: expected results of beats in flight, in arrival order
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int         occ = 0;
  bit         just_acc = 1'b0;
  logic [7:0] m_acc = 8'h00;
  logic [7:0] m_cnt = 8'h00;
  int         txn_no = 0;
  bit         dummy;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] apply_fn(input logic [1:0] s, input logic [7:0] l, input logic [7:0] r);
    case (s)
      2'b00:   return l & r;
      2'b01:   return l | r;
      2'b10:   return l ^ r;
      default: return ~(l & r);
    endcase
  endfunction

  // One clock cycle: check outputs, drive inputs, advance the model
  task automatic step(input bit iv, input logic [1:0] s, input bit am, input bit ac,
                      input logic [7:0] av, input logic [7:0] bv, input bit ordy,
                      output bit accepted);
    bit exp_ov, exp_ir, hs;
    logic [7:0] l, r, e;
    @(negedge clk);
    exp_ov = (occ == 2) || (occ == 1 && !just_acc);
    check_val("out_valid", out_valid, exp_ov);
    if (exp_ov) begin
      check_val("f", f, exp_q[0]);
      check_val("zero", zero, exp_q[0] == 8'h00);
      check_val("parity", parity, ^exp_q[0]);
    end
    check_val("txn_cnt", txn_cnt, m_cnt);
    in_valid  = iv;
    sel       = s;
    acc_mode  = am;
    acc_clr   = ac;
    a         = av;
    b         = bv;
    out_ready = ordy;
    #1;
    exp_ir = !(occ == 2 && !ordy);
    check_val("in_ready", in_ready, exp_ir);
    accepted = iv && exp_ir;
    hs = exp_ov && ordy;
    @(posedge clk);
    if (hs) begin
      e = exp_q.pop_front();
      got_q.push_back(e);
      m_cnt++;
      occ--;
      txn_no++;
      $display("txn %0d: f=%02h cnt=%02h", txn_no, e, m_cnt);
    end
    if (accepted) begin
      l = am ? (ac ? 8'h00 : m_acc) : av;
      r = am ? av : bv;
      e = apply_fn(s, l, r);
      if (am) m_acc = e;
      else if (ac) m_acc = 8'h00;
      exp_q.push_back(e);
      occ++;
    end
    just_acc = accepted;
  endtask

  task automatic drain();
    for (int i = 0; i < 4; i++) step(1'b0, 2'b00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, dummy);
  endtask

  task automatic check_got(input string tag, input logic [7:0] want[$]);
    check_val({tag, "_count"}, got_q.size(), want.size());
    for (int i = 0; i < want.size() && i < got_q.size(); i++)
      check_val(tag, got_q[i], want[i]);
    got_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_val("rst_out_valid", out_valid, 0);
    check_val("rst_f", f, 0);
    check_val("rst_zero", zero, 1);
    check_val("rst_parity", parity, 0);
    check_val("rst_txn_cnt", txn_cnt, 0);
    check_val("rst_in_ready", in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    got_q.delete();
    occ = 0;
    just_acc = 1'b0;
    m_acc = 8'h00;
    m_cnt = 8'h00;
  endtask

  initial begin
    bit acc_ok;
    logic [7:0] want[$];

    do_reset();

    // Function sweep, back-to-back
    for (int s = 0; s < 4; s++) step(1'b1, 2'(s), 1'b0, 1'b0, 8'hF0, 8'h3C, 1'b1, dummy);
    drain();
    want = '{8'h30, 8'hFC, 8'hCC, 8'hCF};
    check_got("sweep", want);

    // Backpressure: two beats buffer, third is refused until out_ready rises
    step(1'b1, 2'b01, 1'b0, 1'b0, 8'h01, 8'h00, 1'b0, acc_ok);
    check_val("bp_acc1", acc_ok, 1);
    step(1'b1, 2'b01, 1'b0, 1'b0, 8'h02, 8'h00, 1'b0, acc_ok);
    check_val("bp_acc2", acc_ok, 1);
    step(1'b1, 2'b01, 1'b0, 1'b0, 8'h03, 8'h00, 1'b0, acc_ok);
    check_val("bp_full", in_ready, 0);
    step(1'b1, 2'b01, 1'b0, 1'b0, 8'h03, 8'h00, 1'b0, acc_ok);
    for (int i = 0; i < 10 && !acc_ok; i++)
      step(1'b1, 2'b01, 1'b0, 1'b0, 8'h03, 8'h00, 1'b1, acc_ok);
    check_val("bp_acc3", acc_ok, 1);
    drain();
    want = '{8'h01, 8'h02, 8'h03};
    check_got("backpressure", want);

    // Accumulate with XOR
    step(1'b1, 2'b10, 1'b1, 1'b1, 8'h0F, 8'h55, 1'b1, dummy);
    step(1'b1, 2'b10, 1'b1, 1'b0, 8'hFF, 8'h55, 1'b1, dummy);
    step(1'b1, 2'b10, 1'b1, 1'b0, 8'hF0, 8'h55, 1'b1, dummy);
    drain();
    want = '{8'h0F, 8'hF0, 8'h00};
    check_got("accum", want);

    // Clear precedence: clear-then-operate
    step(1'b1, 2'b01, 1'b1, 1'b1, 8'hAA, 8'h00, 1'b1, dummy);
    step(1'b1, 2'b01, 1'b1, 1'b1, 8'h05, 8'h00, 1'b1, dummy);
    step(1'b1, 2'b01, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1, dummy);
    drain();
    want = '{8'hAA, 8'h05, 8'h05};
    check_got("clr_prec", want);

    // Randomized traffic
    for (int i = 0; i < 1500; i++)
      step($urandom_range(0, 3) != 0, 2'($urandom), 1'($urandom), $urandom_range(0, 5) == 0,
           8'($urandom), 8'($urandom), $urandom_range(0, 3) != 0, dummy);
    drain();
    got_q.delete();

    // Reset mid-stream discards buffered beats
    step(1'b1, 2'b10, 1'b0, 1'b0, 8'h12, 8'h34, 1'b0, dummy);
    step(1'b1, 2'b10, 1'b0, 1'b0, 8'h56, 8'h78, 1'b0, dummy);
    do_reset();
    drain();
    check_val("rst_no_output", got_q.size(), 0);

    // First beat after reset, then counter wrap
    for (int i = 0; i < 256; i++)
      step(1'b1, 2'($urandom), 1'b0, 1'b0, 8'($urandom), 8'($urandom), 1'b1, dummy);
    drain();
    @(negedge clk);
    check_val("cnt_wrap", txn_cnt, 8'h00);
    step(1'b1, 2'b00, 1'b0, 1'b0, 8'hFF, 8'h81, 1'b1, dummy);
    drain();
    @(negedge clk);
    check_val("cnt_after_wrap", txn_cnt, 8'h01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
